// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: writeback-select codes, load funct3 codes,
// writeback FSM states and the stage-register layout.
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_RSVD = 2'd3;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
  } stage_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half of a word, extends it,
// and flags halfword/word accesses that are not naturally aligned.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Unrecognised funct3 values behave exactly like LW.
  always_comb begin
    case (i_funct3)
      FUNCT3_LB: begin
        o_data       = {{24{w_byte[7]}}, w_byte};
        o_misaligned = 1'b0;
      end
      FUNCT3_LBU: begin
        o_data       = {24'd0, w_byte};
        o_misaligned = 1'b0;
      end
      FUNCT3_LH: begin
        o_data       = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr[0];
      end
      FUNCT3_LHU: begin
        o_data       = {16'd0, w_half};
        o_misaligned = i_addr[0];
      end
      FUNCT3_LW: begin
        o_data       = i_rdata;
        o_misaligned = (i_addr != 2'd0);
      end
      default: begin
        o_data       = i_rdata;
        o_misaligned = (i_addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: waits for load data, aligns it and
// drives the register-file write port. Define WB_FWD_EN to add the fwd_* bypass outputs.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_pc_plus4,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_req,
  output logic        reg_write,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        misalign_err,
  output logic        load_err
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  stage_t        r_s;
  wb_state_e     r_state;
  wb_state_e     w_next_state;
  logic [CW-1:0] r_cnt;
  logic          r_load_err;
  logic [31:0]   w_load_data;
  logic          w_misaligned;
  logic          w_needs_mem;
  logic          w_timeout;
  logic          w_rd_ok;

  load_align u_load_align (
    .i_funct3     (r_s.funct3),
    .i_addr       (r_s.alu_result[1:0]),
    .i_rdata      (dmem_rdata),
    .o_data       (w_load_data),
    .o_misaligned (w_misaligned)
  );

  // dmem handshake: the memory owns the response; dmem_rvalid=1 means dmem_rdata is
  // the answer for the load held in S this cycle. No ready exists, so a response that
  // arrives while S holds no pending load is simply ignored.
  assign w_needs_mem = r_s.valid && (r_s.wb_sel == WB_SEL_LOAD) && !w_misaligned;
  assign w_timeout   = (r_state == ST_WAIT) && !dmem_rvalid && (r_cnt == CW'(LOAD_TIMEOUT));
  assign w_rd_ok     = r_s.reg_write && (r_s.rd != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s <= '0;
    end else if (!stall_req) begin
      r_s.valid      <= mem_valid;
      r_s.reg_write  <= mem_reg_write;
      r_s.rd         <= mem_rd;
      r_s.wb_sel     <= mem_wb_sel;
      r_s.funct3     <= mem_funct3;
      r_s.alu_result <= mem_alu_result;
      r_s.pc_plus4   <= mem_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_needs_mem && !dmem_rvalid) w_next_state = ST_WAIT;
      ST_WAIT: if (dmem_rvalid || w_timeout) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Counter holds the number of cycles the current load has been waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_load_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_next_state == ST_WAIT) begin
        r_cnt <= CW'(1);
      end else if (r_state == ST_WAIT && w_next_state == ST_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_timeout) r_load_err <= 1'b1;
    end
  end

  always_comb begin
    stall_req    = 1'b0;
    reg_write    = 1'b0;
    misalign_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s.valid) begin
          if (r_s.wb_sel == WB_SEL_LOAD) begin
            if (w_misaligned)     misalign_err = 1'b1;
            else if (dmem_rvalid) reg_write    = w_rd_ok;
            else                  stall_req    = 1'b1;
          end else begin
            reg_write = w_rd_ok;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid)     reg_write = w_rd_ok;
        else if (!w_timeout) stall_req = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_s.wb_sel)
      WB_SEL_LOAD: write_data = w_load_data;
      WB_SEL_PC4:  write_data = r_s.pc_plus4;
      WB_SEL_ALU:  write_data = r_s.alu_result;
      WB_SEL_RSVD: write_data = r_s.alu_result;
      default:     write_data = r_s.alu_result;
    endcase
  end

  assign write_addr = r_s.rd;
  assign load_err   = r_load_err;

`ifdef WB_FWD_EN
  assign fwd_valid = reg_write;
  assign fwd_rd    = write_addr;
  assign fwd_data  = write_data;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of single-cycle writebacks, hand-written multi-cycle
// sequences (late load, timeout, reset mid-wait) and random traffic against a model.
module tb_mem_wb_stage;

  localparam int LOAD_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_req;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        misalign_err;
  logic        load_err;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [36:0] exp_q[$];

  mem_wb_stage #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_pc_plus4   (mem_pc_plus4),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .stall_req      (stall_req),
    .reg_write      (reg_write),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .misalign_err   (misalign_err),
    .load_err       (load_err)
`ifdef WB_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive_op(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                          input logic rw, input logic [31:0] alu, input logic [31:0] pc4);
    mem_valid      = 1'b1;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_rd         = rd;
    mem_reg_write  = rw;
    mem_alu_result = alu;
    mem_pc_plus4   = pc4;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // reference model, stated in terms of access size and byte offset
  function automatic int access_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    int off;
    off = int'(addr % 4);
    sh  = rdata >> (8 * off);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  // scoreboard: every register-file write during random traffic must be expected
  always @(negedge clk) begin
    if (mon_en && reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_write actual=%0d:%h required=none", write_addr, write_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("mon_addr", {27'd0, write_addr}, {27'd0, e[36:32]});
        chk("mon_data", write_data, e[31:0]);
      end
    end
  end

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t vt[16];

  task automatic rand_txn(input int idx);
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    int          lat;
    logic        is_load;
    logic        mis;
    logic        we;
    logic [31:0] data;
    sel     = 2'($urandom_range(0, 3));
    f3      = 3'($urandom_range(0, 7));
    rd      = 5'($urandom_range(0, 31));
    rw      = 1'($urandom_range(0, 1));
    alu     = $urandom();
    pc4     = $urandom();
    rdata   = $urandom();
    lat     = $urandom_range(0, 4);
    is_load = (sel == 2'd1);
    mis     = is_load && ((alu % access_size(f3)) != 0);
    we      = rw && (rd != 5'd0) && !mis;
    data    = is_load ? model_load(f3, alu, rdata) : ((sel == 2'd2) ? pc4 : alu);
    drive_op(sel, f3, rd, rw, alu, pc4);
    dmem_rvalid = 1'b0;
    next_edge();
    mem_valid = 1'b0;
    if (is_load && !mis) begin
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_stall", idx), {31'd0, stall_req}, 32'd1);
        next_edge();
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
    end else begin
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom();
    end
    if (we) exp_q.push_back({rd, data});
    @(negedge clk);
    chk($sformatf("rnd%0d_nostall", idx), {31'd0, stall_req}, 32'd0);
    chk($sformatf("rnd%0d_mis", idx), {31'd0, misalign_err}, {31'd0, mis});
    next_edge();
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    int n;
    //                sel   f3      rd   rw  alu           pc4         rv  rdata         we  data          mis
    vt[0]  = '{2'd0, 3'b000, 5'd5,  1, 32'h1234_5678, 32'h0,       0, 32'h0,         1, 32'h1234_5678, 0};
    vt[1]  = '{2'd1, 3'b000, 5'd9,  1, 32'h0000_0103, 32'h0,       1, 32'h80FF_0000, 1, 32'hFFFF_FF80, 0};
    vt[2]  = '{2'd1, 3'b100, 5'd10, 1, 32'h0000_0101, 32'h0,       1, 32'h1234_80AB, 1, 32'h0000_0080, 0};
    vt[3]  = '{2'd1, 3'b001, 5'd11, 1, 32'h0000_0102, 32'h0,       1, 32'h8001_1234, 1, 32'hFFFF_8001, 0};
    vt[4]  = '{2'd1, 3'b101, 5'd12, 1, 32'h0000_0100, 32'h0,       1, 32'h1234_F00D, 1, 32'h0000_F00D, 0};
    vt[5]  = '{2'd1, 3'b010, 5'd13, 1, 32'h0000_0104, 32'h0,       1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0};
    vt[6]  = '{2'd1, 3'b010, 5'd14, 1, 32'h0000_0101, 32'h0,       0, 32'h0,         0, 32'h0,         1};
    vt[7]  = '{2'd1, 3'b001, 5'd15, 1, 32'h0000_0103, 32'h0,       0, 32'h0,         0, 32'h0,         1};
    vt[8]  = '{2'd2, 3'b000, 5'd0,  1, 32'h0000_0999, 32'h40,      0, 32'h0,         0, 32'h0,         0};
    vt[9]  = '{2'd2, 3'b000, 5'd1,  1, 32'h0000_0999, 32'h44,      0, 32'h0,         1, 32'h0000_0044, 0};
    vt[10] = '{2'd3, 3'b000, 5'd2,  1, 32'hCAFE_F00D, 32'h1111,    0, 32'h0,         1, 32'hCAFE_F00D, 0};
    vt[11] = '{2'd0, 3'b000, 5'd4,  0, 32'h5555_AAAA, 32'h0,       0, 32'h0,         0, 32'h0,         0};
    vt[12] = '{2'd1, 3'b011, 5'd16, 1, 32'h0000_0108, 32'h0,       1, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 0};
    vt[13] = '{2'd1, 3'b000, 5'd0,  1, 32'h0000_0100, 32'h0,       1, 32'h0000_00FF, 0, 32'h0,         0};
    vt[14] = '{2'd0, 3'b000, 5'd6,  1, 32'h0000_0077, 32'h0,       1, 32'hFFFF_FFFF, 1, 32'h0000_0077, 0};
    vt[15] = '{2'd1, 3'b111, 5'd17, 1, 32'h0000_0102, 32'h0,       0, 32'h0,         0, 32'h0,         1};

    // reset with garbage on the inputs: nothing may be captured
    reset = 1'b1;
    drive_op(2'd0, 3'b000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_we", {31'd0, reg_write}, 32'd0);
    chk("rst_addr", {27'd0, write_addr}, 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_lerr", {31'd0, load_err}, 32'd0);
    next_edge();

    // table: one instruction per vector, response (if any) in the WB cycle
    for (int i = 0; i < 16; i++) begin
      drive_op(vt[i].sel, vt[i].f3, vt[i].rd, vt[i].rw, vt[i].alu, vt[i].pc4);
      dmem_rvalid = 1'b0;
      next_edge();
      mem_valid   = 1'b0;
      dmem_rvalid = vt[i].rvalid;
      dmem_rdata  = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), {31'd0, reg_write}, {31'd0, vt[i].e_we});
      chk($sformatf("vec%0d_mis", i), {31'd0, misalign_err}, {31'd0, vt[i].e_mis});
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_req}, 32'd0);
      if (vt[i].e_we) begin
        chk($sformatf("vec%0d_addr", i), {27'd0, write_addr}, {27'd0, vt[i].rd});
        chk($sformatf("vec%0d_data", i), write_data, vt[i].e_data);
      end
`ifdef WB_FWD_EN
      chk($sformatf("vec%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vt[i].e_we});
      if (vt[i].e_we) begin
        chk($sformatf("vec%0d_fwd_rd", i), {27'd0, fwd_rd}, {27'd0, vt[i].rd});
        chk($sformatf("vec%0d_fwd_data", i), fwd_data, vt[i].e_data);
      end
`endif
      next_edge();
      dmem_rvalid = 1'b0;
    end

    // misalign flag is a single-cycle pulse
    drive_op(2'd1, 3'b010, 5'd3, 1'b1, 32'h0000_0101, 32'h0);
    next_edge();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("mis_pulse_hi", {31'd0, misalign_err}, 32'd1);
    next_edge();
    @(negedge clk);
    chk("mis_pulse_lo", {31'd0, misalign_err}, 32'd0);
    next_edge();

    // LHU answered three cycles late; the next instruction must be held meanwhile
    drive_op(2'd1, 3'b101, 5'd10, 1'b1, 32'h0000_0102, 32'h0);
    next_edge();
    drive_op(2'd0, 3'b000, 5'd7, 1'b1, 32'h00C0_FFEE, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lhu_stall%0d", k), {31'd0, stall_req}, 32'd1);
      chk($sformatf("lhu_nowrite%0d", k), {31'd0, reg_write}, 32'd0);
      next_edge();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF_0001;
    @(negedge clk);
    chk("lhu_stall_end", {31'd0, stall_req}, 32'd0);
    chk("lhu_we", {31'd0, reg_write}, 32'd1);
    chk("lhu_addr", {27'd0, write_addr}, 32'd10);
    chk("lhu_data", write_data, 32'h0000_BEEF);
    next_edge();
    dmem_rvalid = 1'b0;
    mem_valid   = 1'b0;
    @(negedge clk);
    chk("held_we", {31'd0, reg_write}, 32'd1);
    chk("held_addr", {27'd0, write_addr}, 32'd7);
    chk("held_data", write_data, 32'h00C0_FFEE);
    next_edge();

    // load that never gets a response
    drive_op(2'd1, 3'b010, 5'd3, 1'b1, 32'h0000_0200, 32'h0);
    next_edge();
    mem_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!stall_req) break;
      n++;
      next_edge();
    end
    chk("to_stall_cycles", 32'(n), 32'(LOAD_TIMEOUT));
    chk("to_nowrite", {31'd0, reg_write}, 32'd0);
    next_edge();
    @(negedge clk);
    chk("to_lerr_set", {31'd0, load_err}, 32'd1);
    chk("to_stall_off", {31'd0, stall_req}, 32'd0);
    next_edge();
    drive_op(2'd0, 3'b000, 5'd8, 1'b1, 32'h0000_1234, 32'h0);
    next_edge();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("to_after_we", {31'd0, reg_write}, 32'd1);
    chk("to_lerr_sticky", {31'd0, load_err}, 32'd1);
    next_edge();
    reset = 1'b1;
    next_edge();
    reset = 1'b0;
    @(negedge clk);
    chk("to_lerr_cleared", {31'd0, load_err}, 32'd0);
    next_edge();

    // reset while waiting discards the load; a stray response is ignored
    drive_op(2'd1, 3'b010, 5'd9, 1'b1, 32'h0000_0300, 32'h0);
    next_edge();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rw_stall0", {31'd0, stall_req}, 32'd1);
    next_edge();
    @(negedge clk);
    chk("rw_stall1", {31'd0, stall_req}, 32'd1);
    next_edge();
    reset = 1'b1;
    next_edge();
    reset       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1357_9BDF;
    @(negedge clk);
    chk("rw_stall_off", {31'd0, stall_req}, 32'd0);
    chk("rw_nowrite", {31'd0, reg_write}, 32'd0);
    next_edge();
    dmem_rvalid = 1'b0;

    // random traffic against the model
    mon_en = 1'b1;
    for (int t = 0; t < 200; t++) rand_txn(t);
    @(negedge clk);
    mon_en = 1'b0;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
